// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared core constants and IF/ID payload type
// Purpose: default widths, reset values and the PC stride for the fetch stage,
//          plus the packed IF/ID payload reused by the ID stage.
// Ports:   none (package).
// Config:  FETCH_PERF_CNT_EN enables the fetch-stage perf counters in fetch_stage.
package fetch_stage_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_INSTR_W   = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  // Sequential fetch stride in bytes.
  localparam int unsigned PC_INC = 4;

  // Counters stop at all-ones rather than wrapping.
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
    logic                   valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with hold and flush
// Purpose: holds {pc, instr, valid} presented to ID. Priority rst > flush > hold > load.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   hold               keep current contents
//   flush              insert a bubble (NOP, pc 0, valid 0)
//   next_pc/next_instr payload loaded on an ordinary advance (valid becomes 1)
//   id_pc/id_instr/id_valid registered outputs to ID
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned          ADDR_W    = DEF_ADDR_W,
  parameter int unsigned          INSTR_W   = DEF_INSTR_W,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic [INSTR_W-1:0] next_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!hold) begin
      id_pc    <= next_pc;
      id_instr <= next_instr;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, pending branch and IF/ID
// Purpose: drives instruction-memory address from the PC, advances/holds/redirects
//          the PC and fills the IF/ID register for the ID stage.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   hazard                    ID stall: hold PC and IF/ID
//   mem_stall                 SRAM busy: freeze everything, remember any branch
//   branch_taken/branch_addr  EXE redirect request and target
//   imem_addr/imem_rdata      combinational instruction-memory port (addr = PC)
//   id_pc/id_instr/id_valid   IF/ID contents (id_pc is PC+4 of the instruction)
//   stall_cycles/flush_count  perf counters, present only with FETCH_PERF_CNT_EN
// Config:  `define FETCH_PERF_CNT_EN to build the saturating perf counters;
//          otherwise both counter outputs are tied to zero.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned        ADDR_W    = DEF_ADDR_W,
  parameter int unsigned        INSTR_W   = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard,
  input  logic               mem_stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
);

  logic [ADDR_W-1:0] pc;
  logic              pend_br;
  logic [ADDR_W-1:0] pend_addr;

  logic              eb;          // effective branch: live request or one remembered across a stall
  logic              br_apply;    // branch actually redirects the PC this edge
  logic              stall_edge;  // PC held for a stall rather than a redirect
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_target;

  assign imem_addr  = pc;
  assign eb         = branch_taken | pend_br;
  assign br_apply   = eb & ~mem_stall;
  assign stall_edge = mem_stall | (hazard & ~eb);
  assign pc_plus4   = pc + ADDR_W'(PC_INC);

  // A live request wins over one saved during a stall; the target is word-aligned.
  always_comb begin
    br_target = branch_taken ? branch_addr : pend_addr;
    br_target[1:0] = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      pend_br   <= 1'b0;
      pend_addr <= '0;
    end else if (mem_stall) begin
      // Remember the branch so it is not lost while the pipeline is frozen.
      if (branch_taken) begin
        pend_br   <= 1'b1;
        pend_addr <= branch_addr;
      end
    end else if (eb) begin
      pc      <= br_target;
      pend_br <= 1'b0;
    end else if (!hazard) begin
      pc <= pc_plus4;
    end
  end

  fetch_stage_if_id_reg #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .hold       (stall_edge),
    .flush      (br_apply),
    .next_pc    (pc_plus4),
    .next_instr (imem_rdata),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_valid   (id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_edge && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 32'd1;
      if (br_apply && flush_cnt != CNT_MAX)   flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_count  = flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
